// File: rtl/frame_buffer_reader.sv
// rtl/frame_buffer_reader.sv - raster-order frame readout from 1-cycle-latency RAM onto a pixel stream
module frame_buffer_reader #(
    parameter int X_COUNT    = 320,
    parameter int Y_COUNT    = 240,
    parameter int X_WIDTH    = 9,
    parameter int Y_WIDTH    = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [X_WIDTH-1:0]    pix_x,
    output logic [Y_WIDTH-1:0]    pix_y,
    output logic                  pix_eol,
    output logic                  pix_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(X_COUNT * Y_COUNT - 1);
    localparam logic [X_WIDTH-1:0]    X_LAST    = X_WIDTH'(X_COUNT - 1);
    localparam int TAG_W   = X_WIDTH + Y_WIDTH + 2;
    localparam int ENTRY_W = DATA_WIDTH + TAG_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic [X_WIDTH-1:0]   x_cnt;
    logic [Y_WIDTH-1:0]   y_cnt;
    logic                 inflight;
    logic [TAG_W-1:0]     tag;
    logic [ENTRY_W-1:0]   fifo_mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 pop;
    logic [2:0]           occ_next;

    assign pix_valid = (count != 2'd0);
    assign pop       = pix_valid & pix_ready;
    // Occupancy once this cycle's returning read lands and the head leaves;
    // a new read is only allowed if its data will still find a free slot.
    assign occ_next  = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en     = (state == RUN) && (occ_next < 3'd2);

    assign {pix_data, pix_x, pix_y, pix_eol, pix_last} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_addr     <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            inflight    <= 1'b0;
            tag         <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            done     <= 1'b0;
            inflight <= rd_en;
            count    <= occ_next[1:0];
            if (rd_en) begin
                tag <= {x_cnt, y_cnt, (x_cnt == X_LAST), (rd_addr == ADDR_LAST)};
            end
            if (inflight) begin
                fifo_mem[wr_ptr] <= {rd_data, tag};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        rd_addr <= '0;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        if (rd_addr == ADDR_LAST) begin
                            state <= DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                            if (x_cnt == X_LAST) begin
                                x_cnt <= '0;
                                y_cnt <= y_cnt + Y_WIDTH'(1);
                            end else begin
                                x_cnt <= x_cnt + X_WIDTH'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    // No reads issue here, so the FIFO empties once occ_next hits zero.
                    if (occ_next == 3'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb/tb_frame_buffer_reader.sv - randomized self-checking bench for frame_buffer_reader
module tb_frame_buffer_reader;

    localparam int XC = 40;
    localparam int YC = 25;
    localparam int N  = XC * YC;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic        pix_eol;
    logic        pix_last;

    frame_buffer_reader #(.X_COUNT(XC), .Y_COUNT(YC)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol), .pix_last(pix_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM whose content is simply its own address.
    always @(posedge clk) if (rd_en) rd_data <= rd_addr[15:0];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: pixel k of a frame is (k % XC, k / XC) carrying data k.
    bit mon_en    = 1'b0;
    int issue_idx = 0;
    int acc_idx   = 0;
    int done_cnt  = 0;

    always @(negedge clk) begin : monitor
        int acc_after;
        if (mon_en) begin
            acc_after = acc_idx + ((pix_valid && pix_ready) ? 1 : 0);
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(issue_idx));
                issue_idx++;
                check("outstanding_le2", 32'((issue_idx - acc_after) <= 2), 32'd1);
            end
            if (pix_valid) begin
                check("pix_data", 32'(pix_data), 32'(acc_idx & 16'hffff));
                check("pix_x", 32'(pix_x), 32'(acc_idx % XC));
                check("pix_y", 32'(pix_y), 32'(acc_idx / XC));
                check("pix_eol", 32'(pix_eol), 32'((acc_idx % XC) == XC - 1));
                check("pix_last", 32'(pix_last), 32'(acc_idx == N - 1));
            end
            if (done) begin
                done_cnt++;
                check("done_all_pixels", 32'(acc_idx), 32'(N));
                check("done_no_valid", 32'(pix_valid), 32'd0);
            end
            acc_idx = acc_after;
        end
    end

    // mode 0: ready high, 1: ready low for 5 cycles mid-frame, 2: random ready.
    task automatic run_frame(input int mode, input int restart_cyc, input bit post_idle,
                             output int first_v, output int done_c);
        int cyc;
        first_v   = -1;
        done_c    = -1;
        issue_idx = 0;
        acc_idx   = 0;
        done_cnt  = 0;
        mon_en    = 1'b1;
        start     = 1'b1;
        pix_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc       = 0;
        while (cyc < 20 * N) begin
            @(negedge clk);
            if (cyc == 0) check("busy_in_start_cycle", 32'(busy), 32'd0);
            if (cyc == 1) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("rd_en_first", 32'(rd_en), 32'd1);
            end
            if (pix_valid && first_v < 0) first_v = cyc;
            if (done) begin
                done_c = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == restart_cyc);
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = !(cyc >= 60 && cyc < 65);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
        start = 1'b0;
        if (done_c < 0) check("frame_timeout", 32'd0, 32'd1);
        if (post_idle) begin
            repeat (5) @(negedge clk);
            check("single_done", 32'(done_cnt), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_x", 32'(pix_x), 32'd0);
        check("rst_pix_y", 32'(pix_y), 32'd0);
        check("rst_pix_eol", 32'(pix_eol), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
    endtask

    initial begin
        int fv;
        int dc;
        int guard;
        rst       = 1'b1;
        start     = 1'b0;
        pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full frame, ready always high: latency and throughput.
        run_frame(0, -1, 1'b1, fv, dc);
        check("first_valid_latency", 32'(fv), 32'd3);
        check("done_latency", 32'(dc), 32'(3 + N));
        @(posedge clk);
        #1;

        // Five-cycle stall mid-frame.
        run_frame(1, -1, 1'b1, fv, dc);
        check("bp_done_latency", 32'(dc), 32'(3 + N + 5));
        @(posedge clk);
        #1;

        // Random backpressure.
        run_frame(2, -1, 1'b1, fv, dc);
        @(posedge clk);
        #1;

        // Extra start while busy, then restart right after done.
        run_frame(0, 30, 1'b0, fv, dc);
        check("restart_ignored_done", 32'(dc), 32'(3 + N));
        @(posedge clk);
        #1;
        run_frame(0, -1, 1'b1, fv, dc);
        check("second_frame_latency", 32'(fv), 32'd3);
        @(posedge clk);
        #1;

        // Reset mid-frame.
        issue_idx = 0;
        acc_idx   = 0;
        done_cnt  = 0;
        mon_en    = 1'b1;
        start     = 1'b1;
        pix_ready = 1'b1;
        guard     = 0;
        while (acc_idx < 500 && guard < 10 * N) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            guard++;
        end
        check("reach_pixel_500", 32'(acc_idx >= 500), 32'd1);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(pix_valid), 32'd0);
            check("post_rst_no_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        run_frame(0, -1, 1'b1, fv, dc);
        check("after_rst_latency", 32'(fv), 32'd3);
        check("after_rst_done", 32'(dc), 32'(3 + N));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
